bft_stream_tx: RTL and testbench



---
 rtl/bft_stream_tx_if.sv | 25 ++
 rtl/bft_stream_tx.sv | 95 +++++++++
 tb/tb_bft_stream_tx.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bft_stream_tx_if.sv
// rtl/bft_stream_tx_if.sv - user stream and BFT packet bus signals of the transmit packetizer
interface bft_stream_tx_if #(
    parameter int PACKET_BITS  = 49,
    parameter int PAYLOAD_BITS = 32
);
    logic [PAYLOAD_BITS-1:0] Input_1_TDATA;
    logic                    Input_1_TVALID;
    logic                    Input_1_TREADY;
    logic [PACKET_BITS-1:0]  dout_tx2bft;
    logic                    bft_ready;
    logic [PACKET_BITS-1:0]  din_bft2tx;
    logic                    resend;
    logic [31:0]             sent_cnt;
    logic [31:0]             stall_cnt;

    modport slave (
        input  Input_1_TDATA, Input_1_TVALID, bft_ready, din_bft2tx, resend,
        output Input_1_TREADY, dout_tx2bft, sent_cnt, stall_cnt
    );

    modport master (
        output Input_1_TDATA, Input_1_TVALID, bft_ready, din_bft2tx, resend,
        input  Input_1_TREADY, dout_tx2bft, sent_cnt, stall_cnt
    );
endinterface

// File: rtl/bft_stream_tx.sv
// rtl/bft_stream_tx.sv - credit-controlled packetizer from a 32-bit user stream to BFT packets
module bft_stream_tx #(
    parameter int PACKET_BITS           = 49,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int DEST_LEAF             = 0,
    parameter int DEST_PORT             = 2,
    parameter int CREDIT_PORT           = 1
) (
    input logic             ap_clk,
    input logic             ap_rst_n,
    bft_stream_tx_if.slave  bus
);
    localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;
    localparam int MAX_CREDIT  = 1 << NUM_ADDR_BITS;
    localparam int PORT_LSB    = PAYLOAD_BITS + NUM_ADDR_BITS;
    localparam int LEAF_LSB    = PORT_LSB + NUM_PORT_BITS;

    logic [PACKET_BITS-1:0]   pkt_q;
    logic                     pkt_vld;
    logic [NUM_ADDR_BITS-1:0] addr_q;
    logic [CREDIT_BITS-1:0]   credit_q;
    logic [31:0]              sent_q;
    logic [31:0]              stall_q;

    logic                     tready;
    logic                     acc;
    logic                     drain;
    logic                     upd;
    logic [CREDIT_BITS:0]     credit_sum;
    logic [CREDIT_BITS-1:0]   credit_next;

    // Only the valid bit and port field of incoming traffic matter here.
    logic unused_din;
    assign unused_din = ^{bus.din_bft2tx[LEAF_LSB +: NUM_LEAF_BITS],
                          bus.din_bft2tx[PORT_LSB-1:0]};

    // Ready is held low in reset so nothing is taken before the first live edge.
    assign tready = ap_rst_n & ~bus.resend & (credit_q != '0) & (~pkt_vld | bus.bft_ready);
    assign acc    = bus.Input_1_TVALID & tready;
    assign drain  = bus.bft_ready & pkt_vld & ~bus.resend;
    assign upd    = bus.din_bft2tx[PACKET_BITS-1] &
                    (bus.din_bft2tx[PORT_LSB +: NUM_PORT_BITS] == NUM_PORT_BITS'(CREDIT_PORT));

    // One extra bit of headroom so an update on a full counter can be clamped.
    always_comb begin
        credit_sum = {1'b0, credit_q};
        if (upd) begin
            credit_sum = credit_sum + (CREDIT_BITS+1)'(FREESPACE_UPDATE_SIZE);
        end
        if (acc) begin
            credit_sum = credit_sum - (CREDIT_BITS+1)'(1);
        end
        credit_next = credit_sum[CREDIT_BITS-1:0];
        if (credit_sum > (CREDIT_BITS+1)'(MAX_CREDIT)) begin
            credit_next = CREDIT_BITS'(MAX_CREDIT);
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            pkt_q    <= '0;
            pkt_vld  <= 1'b0;
            addr_q   <= '0;
            credit_q <= CREDIT_BITS'(MAX_CREDIT);
            sent_q   <= '0;
            stall_q  <= '0;
        end else begin
            if (acc) begin
                pkt_q   <= {1'b1, NUM_LEAF_BITS'(DEST_LEAF), NUM_PORT_BITS'(DEST_PORT),
                            addr_q, bus.Input_1_TDATA};
                pkt_vld <= 1'b1;
                addr_q  <= addr_q + 1'b1;
            end else if (drain) begin
                pkt_vld <= 1'b0;
            end
            credit_q <= credit_next;
            if (drain) begin
                sent_q <= sent_q + 32'd1;
            end
            if (bus.Input_1_TVALID && credit_q == '0) begin
                stall_q <= stall_q + 32'd1;
            end
        end
    end

    // A resend pause blanks the bus but keeps the packet for re-presentation.
    assign bus.dout_tx2bft    = (pkt_vld & ~bus.resend) ? pkt_q : '0;
    assign bus.Input_1_TREADY = tready;
    assign bus.sent_cnt       = sent_q;
    assign bus.stall_cnt      = stall_q;
endmodule

// File: tb/tb_bft_stream_tx.sv
// tb/tb_bft_stream_tx.sv - directed self-checking bench for bft_stream_tx
module tb_bft_stream_tx;
    logic ap_clk = 1'b0;
    logic ap_rst_n;
    int   total = 0;
    int   bad   = 0;

    localparam logic [48:0] UPD_PKT = {1'b1, 5'd0, 4'd1, 39'd0};

    always #5 ap_clk = ~ap_clk;

    bft_stream_tx_if bus ();

    bft_stream_tx dut (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .bus      (bus)
    );

    function automatic logic [48:0] mk(input logic [6:0] a, input logic [31:0] d);
        return {1'b1, 5'd0, 4'd2, a, d};
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic test_reset();
        bus.Input_1_TVALID = 1'b0;
        bus.Input_1_TDATA  = '0;
        bus.bft_ready      = 1'b1;
        bus.din_bft2tx     = '0;
        bus.resend         = 1'b0;
        ap_rst_n           = 1'b0;
        #12;
        total++; if (bus.Input_1_TREADY !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b exp=0", bus.Input_1_TREADY); end
        total++; if (bus.dout_tx2bft !== 49'd0) begin bad++; $display("FAIL reset_dout got=%h exp=0", bus.dout_tx2bft); end
        total++; if (bus.sent_cnt !== 32'd0) begin bad++; $display("FAIL reset_sent got=%0d exp=0", bus.sent_cnt); end
        total++; if (bus.stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_cnt); end
        ap_rst_n = 1'b1;
        tick();
        total++; if (bus.Input_1_TREADY !== 1'b1) begin bad++; $display("FAIL post_reset_tready got=%b exp=1", bus.Input_1_TREADY); end
        total++; if (bus.dout_tx2bft !== 49'd0) begin bad++; $display("FAIL post_reset_dout got=%h exp=0", bus.dout_tx2bft); end
    endtask

    task automatic test_fill();
        int n = 0;
        logic r;
        for (int c = 0; c < 133; c++) begin
            bus.Input_1_TVALID = 1'b1;
            bus.Input_1_TDATA  = 32'(32'hA0 + n);
            bus.bft_ready      = 1'b1;
            #1;
            r = bus.Input_1_TREADY;
            total++; if (r !== (n < 128)) begin bad++; $display("FAIL fill_tready cyc=%0d got=%b exp=%b", c, r, (n < 128)); end
            tick();
            if (r) begin
                total++; if (bus.dout_tx2bft !== mk(7'(n), 32'(32'hA0 + n))) begin bad++; $display("FAIL fill_pkt n=%0d got=%h exp=%h", n, bus.dout_tx2bft, mk(7'(n), 32'(32'hA0 + n))); end
                if (n == 0) begin
                    total++; if (bus.dout_tx2bft !== 49'h1_0100_0000_00A0) begin bad++; $display("FAIL fill_pkt0 got=%h exp=%h", bus.dout_tx2bft, 49'h1_0100_0000_00A0); end
                end
                n++;
            end
        end
        bus.Input_1_TVALID = 1'b0;
        #1;
        total++; if (n !== 128) begin bad++; $display("FAIL fill_count got=%0d exp=128", n); end
        total++; if (bus.stall_cnt !== 32'd5) begin bad++; $display("FAIL fill_stall got=%0d exp=5", bus.stall_cnt); end
        total++; if (bus.sent_cnt !== 32'd128) begin bad++; $display("FAIL fill_sent got=%0d exp=128", bus.sent_cnt); end
        total++; if (bus.dout_tx2bft !== 49'd0) begin bad++; $display("FAIL fill_idle_dout got=%h exp=0", bus.dout_tx2bft); end
        total++; if (bus.Input_1_TREADY !== 1'b0) begin bad++; $display("FAIL fill_nocredit_tready got=%b exp=0", bus.Input_1_TREADY); end
        tick();
    endtask

    task automatic test_replenish();
        int n = 0;
        logic r;
        bus.din_bft2tx = UPD_PKT;
        #1;
        total++; if (bus.Input_1_TREADY !== 1'b0) begin bad++; $display("FAIL repl_before got=%b exp=0", bus.Input_1_TREADY); end
        tick();
        bus.din_bft2tx = '0;
        #1;
        total++; if (bus.Input_1_TREADY !== 1'b1) begin bad++; $display("FAIL repl_after got=%b exp=1", bus.Input_1_TREADY); end
        for (int c = 0; c < 70; c++) begin
            bus.Input_1_TVALID = 1'b1;
            bus.Input_1_TDATA  = 32'(32'h500 + n);
            #1;
            r = bus.Input_1_TREADY;
            total++; if (r !== (n < 64)) begin bad++; $display("FAIL repl_tready cyc=%0d got=%b exp=%b", c, r, (n < 64)); end
            tick();
            if (r) begin
                total++; if (bus.dout_tx2bft !== mk(7'(n), 32'(32'h500 + n))) begin bad++; $display("FAIL repl_pkt n=%0d got=%h exp=%h", n, bus.dout_tx2bft, mk(7'(n), 32'(32'h500 + n))); end
                n++;
            end
        end
        bus.Input_1_TVALID = 1'b0;
        total++; if (n !== 64) begin bad++; $display("FAIL repl_count got=%0d exp=64", n); end
        total++; if (bus.sent_cnt !== 32'd192) begin bad++; $display("FAIL repl_sent got=%0d exp=192", bus.sent_cnt); end
        total++; if (bus.stall_cnt !== 32'd11) begin bad++; $display("FAIL repl_stall got=%0d exp=11", bus.stall_cnt); end
    endtask

    task automatic test_backpressure();
        bus.din_bft2tx = UPD_PKT;
        tick();
        bus.din_bft2tx     = '0;
        bus.Input_1_TVALID = 1'b1;
        bus.Input_1_TDATA  = 32'hB00;
        bus.bft_ready      = 1'b0;
        #1;
        total++; if (bus.Input_1_TREADY !== 1'b1) begin bad++; $display("FAIL bp_first_tready got=%b exp=1", bus.Input_1_TREADY); end
        tick();
        bus.Input_1_TDATA = 32'hB01;
        for (int c = 0; c < 5; c++) begin
            #1;
            total++; if (bus.Input_1_TREADY !== 1'b0) begin bad++; $display("FAIL bp_tready cyc=%0d got=%b exp=0", c, bus.Input_1_TREADY); end
            tick();
            total++; if (bus.dout_tx2bft !== mk(7'd64, 32'hB00)) begin bad++; $display("FAIL bp_dout cyc=%0d got=%h exp=%h", c, bus.dout_tx2bft, mk(7'd64, 32'hB00)); end
            total++; if (bus.sent_cnt !== 32'd192) begin bad++; $display("FAIL bp_sent cyc=%0d got=%0d exp=192", c, bus.sent_cnt); end
        end
        bus.Input_1_TVALID = 1'b0;
        bus.bft_ready      = 1'b1;
        tick();
        total++; if (bus.dout_tx2bft !== 49'd0) begin bad++; $display("FAIL bp_drain_dout got=%h exp=0", bus.dout_tx2bft); end
        total++; if (bus.sent_cnt !== 32'd193) begin bad++; $display("FAIL bp_drain_sent got=%0d exp=193", bus.sent_cnt); end
        total++; if (bus.stall_cnt !== 32'd11) begin bad++; $display("FAIL bp_stall got=%0d exp=11", bus.stall_cnt); end
    endtask

    task automatic test_resend();
        bus.Input_1_TVALID = 1'b1;
        bus.Input_1_TDATA  = 32'hC00;
        tick();
        total++; if (bus.dout_tx2bft !== mk(7'd65, 32'hC00)) begin bad++; $display("FAIL rs_pkt65 got=%h exp=%h", bus.dout_tx2bft, mk(7'd65, 32'hC00)); end
        bus.Input_1_TDATA = 32'hC01;
        tick();
        total++; if (bus.dout_tx2bft !== mk(7'd66, 32'hC01)) begin bad++; $display("FAIL rs_pkt66 got=%h exp=%h", bus.dout_tx2bft, mk(7'd66, 32'hC01)); end
        bus.Input_1_TDATA = 32'hC02;
        bus.resend        = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (bus.dout_tx2bft !== 49'd0) begin bad++; $display("FAIL rs_dout cyc=%0d got=%h exp=0", c, bus.dout_tx2bft); end
            total++; if (bus.Input_1_TREADY !== 1'b0) begin bad++; $display("FAIL rs_tready cyc=%0d got=%b exp=0", c, bus.Input_1_TREADY); end
            tick();
        end
        bus.resend = 1'b0;
        #1;
        total++; if (bus.dout_tx2bft !== mk(7'd66, 32'hC01)) begin bad++; $display("FAIL rs_reemit got=%h exp=%h", bus.dout_tx2bft, mk(7'd66, 32'hC01)); end
        total++; if (bus.sent_cnt !== 32'd194) begin bad++; $display("FAIL rs_sent_hold got=%0d exp=194", bus.sent_cnt); end
        tick();
        total++; if (bus.dout_tx2bft !== mk(7'd67, 32'hC02)) begin bad++; $display("FAIL rs_pkt67 got=%h exp=%h", bus.dout_tx2bft, mk(7'd67, 32'hC02)); end
        bus.Input_1_TVALID = 1'b0;
        tick();
        total++; if (bus.sent_cnt !== 32'd196) begin bad++; $display("FAIL rs_sent got=%0d exp=196", bus.sent_cnt); end
    endtask

    task automatic test_simultaneous();
        int n = 0;
        logic r;
        for (int k = 0; k < 59; k++) begin
            bus.Input_1_TVALID = 1'b1;
            bus.Input_1_TDATA  = 32'(32'hD00 + k);
            #1;
            total++; if (bus.Input_1_TREADY !== 1'b1) begin bad++; $display("FAIL sim_pre_tready k=%0d got=%b exp=1", k, bus.Input_1_TREADY); end
            tick();
            total++; if (bus.dout_tx2bft !== mk(7'(68 + k), 32'(32'hD00 + k))) begin bad++; $display("FAIL sim_pre_pkt k=%0d got=%h exp=%h", k, bus.dout_tx2bft, mk(7'(68 + k), 32'(32'hD00 + k))); end
        end
        bus.Input_1_TDATA = 32'hE00;
        bus.din_bft2tx    = UPD_PKT;
        #1;
        total++; if (bus.Input_1_TREADY !== 1'b1) begin bad++; $display("FAIL sim_last_tready got=%b exp=1", bus.Input_1_TREADY); end
        tick();
        bus.din_bft2tx = '0;
        total++; if (bus.dout_tx2bft !== mk(7'd127, 32'hE00)) begin bad++; $display("FAIL sim_pkt127 got=%h exp=%h", bus.dout_tx2bft, mk(7'd127, 32'hE00)); end
        for (int c = 0; c < 70; c++) begin
            bus.Input_1_TDATA = 32'(32'hE01 + n);
            #1;
            r = bus.Input_1_TREADY;
            total++; if (r !== (n < 64)) begin bad++; $display("FAIL sim_tready cyc=%0d got=%b exp=%b", c, r, (n < 64)); end
            tick();
            if (r) begin
                total++; if (bus.dout_tx2bft !== mk(7'(n), 32'(32'hE01 + n))) begin bad++; $display("FAIL sim_pkt n=%0d got=%h exp=%h", n, bus.dout_tx2bft, mk(7'(n), 32'(32'hE01 + n))); end
                n++;
            end
        end
        bus.Input_1_TVALID = 1'b0;
        total++; if (n !== 64) begin bad++; $display("FAIL sim_count got=%0d exp=64", n); end
        total++; if (bus.sent_cnt !== 32'd320) begin bad++; $display("FAIL sim_sent got=%0d exp=320", bus.sent_cnt); end
        total++; if (bus.stall_cnt !== 32'd17) begin bad++; $display("FAIL sim_stall got=%0d exp=17", bus.stall_cnt); end
    endtask

    task automatic test_saturate();
        int n = 0;
        logic r;
        bus.din_bft2tx = UPD_PKT;
        tick();
        tick();
        tick();
        bus.din_bft2tx = '0;
        for (int c = 0; c < 132; c++) begin
            bus.Input_1_TVALID = 1'b1;
            bus.Input_1_TDATA  = 32'(32'hF00 + n);
            #1;
            r = bus.Input_1_TREADY;
            total++; if (r !== (n < 128)) begin bad++; $display("FAIL sat_tready cyc=%0d got=%b exp=%b", c, r, (n < 128)); end
            tick();
            if (r) begin
                total++; if (bus.dout_tx2bft !== mk(7'(64 + n), 32'(32'hF00 + n))) begin bad++; $display("FAIL sat_pkt n=%0d got=%h exp=%h", n, bus.dout_tx2bft, mk(7'(64 + n), 32'(32'hF00 + n))); end
                n++;
            end
        end
        bus.Input_1_TVALID = 1'b0;
        total++; if (n !== 128) begin bad++; $display("FAIL sat_count got=%0d exp=128", n); end
        total++; if (bus.sent_cnt !== 32'd448) begin bad++; $display("FAIL sat_sent got=%0d exp=448", bus.sent_cnt); end
        total++; if (bus.stall_cnt !== 32'd21) begin bad++; $display("FAIL sat_stall got=%0d exp=21", bus.stall_cnt); end
    endtask

    task automatic test_async_reset();
        int n = 0;
        logic r;
        bus.din_bft2tx = UPD_PKT;
        tick();
        bus.din_bft2tx     = '0;
        bus.Input_1_TVALID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.Input_1_TDATA = 32'(32'h1000 + k);
            tick();
        end
        total++; if (bus.dout_tx2bft !== mk(7'd66, 32'h1002)) begin bad++; $display("FAIL ar_pre_pkt got=%h exp=%h", bus.dout_tx2bft, mk(7'd66, 32'h1002)); end
        #2;
        ap_rst_n = 1'b0;
        #1;
        total++; if (bus.dout_tx2bft !== 49'd0) begin bad++; $display("FAIL ar_dout got=%h exp=0", bus.dout_tx2bft); end
        total++; if (bus.Input_1_TREADY !== 1'b0) begin bad++; $display("FAIL ar_tready got=%b exp=0", bus.Input_1_TREADY); end
        total++; if (bus.sent_cnt !== 32'd0) begin bad++; $display("FAIL ar_sent got=%0d exp=0", bus.sent_cnt); end
        total++; if (bus.stall_cnt !== 32'd0) begin bad++; $display("FAIL ar_stall got=%0d exp=0", bus.stall_cnt); end
        bus.Input_1_TVALID = 1'b0;
        #3;
        ap_rst_n = 1'b1;
        tick();
        total++; if (bus.dout_tx2bft !== 49'd0) begin bad++; $display("FAIL ar_release_dout got=%h exp=0", bus.dout_tx2bft); end
        for (int c = 0; c < 130; c++) begin
            bus.Input_1_TVALID = 1'b1;
            bus.Input_1_TDATA  = 32'(32'h2000 + n);
            #1;
            r = bus.Input_1_TREADY;
            total++; if (r !== (n < 128)) begin bad++; $display("FAIL ar_tready cyc=%0d got=%b exp=%b", c, r, (n < 128)); end
            tick();
            if (r) begin
                total++; if (bus.dout_tx2bft !== mk(7'(n), 32'(32'h2000 + n))) begin bad++; $display("FAIL ar_pkt n=%0d got=%h exp=%h", n, bus.dout_tx2bft, mk(7'(n), 32'(32'h2000 + n))); end
                n++;
            end
        end
        bus.Input_1_TVALID = 1'b0;
        total++; if (n !== 128) begin bad++; $display("FAIL ar_count got=%0d exp=128", n); end
        total++; if (bus.sent_cnt !== 32'd128) begin bad++; $display("FAIL ar_sent_final got=%0d exp=128", bus.sent_cnt); end
        total++; if (bus.stall_cnt !== 32'd2) begin bad++; $display("FAIL ar_stall_final got=%0d exp=2", bus.stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_replenish();
        test_backpressure();
        test_resend();
        test_simultaneous();
        test_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
